// File: rtl/stream_demux_1xn_pkg.sv
// stream_demux_1xn_pkg: shared sizing helper and channel-slice convention
package stream_demux_1xn_pkg;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int slice_lo(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/stream_demux_1xn_if.sv
// stream_demux_1xn_if: input stream plus packed per-channel output streams
interface stream_demux_1xn_if
  import stream_demux_1xn_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 8
);
  localparam int SEL_WIDTH = clog2_min1(N);
  logic [WIDTH-1:0]   in_data;
  logic [SEL_WIDTH-1:0] in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/stream_demux_1xn_slot.sv
// demux_out_slot: one-entry output holding register with same-edge reload
module demux_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_accept
);
  assign can_accept = ~valid | ready_in;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= load | (valid & ~ready_in);
      if (load) data <= data_in;
    end
  end
endmodule

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: registered 1-to-N stream demux, select or round-robin steering
module stream_demux_1xn
  import stream_demux_1xn_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stream_demux_1xn_if.slave        bus,
  input  logic                     rr_en,
  output logic [clog2_min1(N)-1:0] rr_ptr,
  output logic                     err_sel
);
  localparam int SEL_WIDTH = clog2_min1(N);
  logic [SEL_WIDTH-1:0] t;
  logic                 t_ok;
  logic                 acc;
  logic [N-1:0]         can_acc;
  logic [N-1:0]         load;
  assign t    = rr_en ? rr_ptr : bus.in_sel;
  assign t_ok = int'(t) < N;
  assign acc  = bus.in_valid & bus.in_ready;
  // out-of-range targets fall through with ready=1 so the beat is consumed and dropped
  always_comb begin
    load         = '0;
    bus.in_ready = rst_n;
    for (int i = 0; i < N; i++) begin
      if (t == SEL_WIDTH'(i)) begin
        bus.in_ready = rst_n & can_acc[i];
        load[i]      = rst_n & bus.in_valid & can_acc[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      err_sel <= 1'b0;
    end else begin
      if (acc & ~t_ok) err_sel <= 1'b1;
      if (acc & rr_en) rr_ptr <= (rr_ptr == SEL_WIDTH'(N - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_slot
    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load[i]),
      .data_in    (bus.in_data),
      .ready_in   (bus.out_ready[i]),
      .valid      (bus.out_valid[i]),
      .data       (bus.out_data[slice_lo(i, WIDTH) +: WIDTH]),
      .can_accept (can_acc[i])
    );
  end
endmodule
